// File: rtl/m_pkg.sv
// Shared types for the symbol-match engine.
// Optional feature macro: M_MATCH_MASK_EN adds a per-channel compare mask.
// Config fields are sized to the widest supported build; the top zero-extends
// its narrower parameterised fields into them, and the unused upper bits
// stay constant.
package m_pkg;

    localparam int CFG_W_DATA      = 256;
    localparam int CFG_W_OFF       = 16;
    localparam int CFG_W_BUF       = 8;
    localparam int DEFAULT_BUF_DEF = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } m_state_e;

    typedef struct packed {
        logic                  en;
        logic [CFG_W_OFF-1:0]  off;
        logic [CFG_W_DATA-1:0] match;
        logic [CFG_W_BUF-1:0]  buffer;
`ifdef M_MATCH_MASK_EN
        logic [CFG_W_DATA-1:0] mask;
`endif
    } m_match_cfg_t;

    // Channel disabled; the mask (when present) compares every bit.
    function automatic m_match_cfg_t cfg_reset();
        m_match_cfg_t c;
        c = '0;
`ifdef M_MATCH_MASK_EN
        c.mask = '1;
`endif
        return c;
    endfunction

endpackage

// File: rtl/m_match_chan.sv
// One match channel: staging/active rule registers, word compare, hit flag.
// Optional feature macro: M_MATCH_MASK_EN (masked compare).
module m_match_chan
    import m_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  m_match_cfg_t          wr_cfg,
    input  logic                  load,
    input  logic                  beat,
    input  logic                  sop,
    input  logic [CFG_W_OFF:0]    idx,
    input  logic [CFG_W_DATA-1:0] data,
    output logic                  hit,
    output logic [CFG_W_BUF-1:0]  buffer
);

    m_match_cfg_t stage;
    m_match_cfg_t act;
    m_match_cfg_t eff;
    logic         hit_q;
    logic         eq;
    logic         cur;

    // On an SOP beat the freshly loaded rules are the ones that apply.
    always_comb begin
        eff = load ? stage : act;
`ifdef M_MATCH_MASK_EN
        eq  = ((data ^ eff.match) & eff.mask) == '0;
`else
        eq  = data == eff.match;
`endif
        cur    = eff.en && (idx == {1'b0, eff.off}) && eq;
        hit    = cur || (!sop && hit_q);
        buffer = eff.buffer;
    end

    // Staging takes writes any time; active only changes at packet start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= cfg_reset();
            act   <= cfg_reset();
            hit_q <= 1'b0;
        end else begin
            if (wr)   stage <= wr_cfg;
            if (load) act   <= stage;
            if (beat) hit_q <= hit;
        end
    end

endmodule

// File: rtl/m_match_engine.sv
// N-channel symbol-match engine: tags each packet's EOP beat with the buffer
// ID of the lowest-index channel whose word-offset compare hit.
// Optional feature macro: M_MATCH_MASK_EN (cfg_mask_w port, masked compare).
module m_match_engine
    import m_pkg::*;
#(
    parameter int N_CH                    = 4,
    parameter int W_DATA                  = 64,
    parameter int W_OFF                   = 8,
    parameter int W_LEN                   = 16,
    parameter int W_BUF                   = 2,
    parameter logic [W_BUF-1:0] DEFAULT_BUF = W_BUF'(DEFAULT_BUF_DEF),
    localparam int W_CH                   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_net,
    input  logic              rst_net,
    input  logic              in_vld_w,
    input  logic              in_sop_w,
    input  logic              in_eop_w,
    input  logic [W_LEN-1:0]  in_length_w,
    input  logic [W_DATA-1:0] in_data_w,
    input  logic              cfg_vld_w,
    input  logic [W_CH-1:0]   cfg_ch_w,
    input  logic              cfg_en_w,
    input  logic [W_OFF-1:0]  cfg_off_w,
    input  logic [W_DATA-1:0] cfg_match_w,
    input  logic [W_BUF-1:0]  cfg_buffer_w,
`ifdef M_MATCH_MASK_EN
    input  logic [W_DATA-1:0] cfg_mask_w,
`endif
    output logic              out_vld_r,
    output logic              out_sop_r,
    output logic              out_eop_r,
    output logic [W_LEN-1:0]  out_length_r,
    output logic [W_DATA-1:0] out_data_r,
    output logic              out_buffer_vld_r,
    output logic [W_BUF-1:0]  out_buffer_r,
    output logic              out_err_r
);

    // 2^W_OFF: one past the largest offset, so a saturated counter never hits.
    localparam logic [W_OFF:0] CNT_SAT = {1'b1, {W_OFF{1'b0}}};

    m_state_e                          state;
    logic [W_OFF:0]                    cnt;
    logic [W_OFF:0]                    idx;
    logic [W_OFF:0]                    cnt_nxt;
    logic                              acc;
    logic                              err;
    logic                              load;
    m_match_cfg_t                      wr_cfg;
    logic [N_CH-1:0]                   ch_wr;
    logic [N_CH-1:0]                   ch_hit;
    logic [N_CH-1:0][CFG_W_BUF-1:0]    ch_buf;
    logic [W_BUF-1:0]                  sel_buf;

    // Beat qualification, word index of the current beat and counter update.
    always_comb begin
        acc     = in_vld_w && (in_sop_w || state == ST_PKT);
        err     = in_vld_w && (in_sop_w == (state == ST_PKT));
        load    = in_vld_w && in_sop_w;
        idx     = in_sop_w ? '0 : cnt;
        cnt_nxt = (idx == CNT_SAT) ? CNT_SAT : idx + 1'b1;
    end

    // Widen the staging write into the shared config record.
    always_comb begin
        wr_cfg        = cfg_reset();
        wr_cfg.en     = cfg_en_w;
        wr_cfg.off    = CFG_W_OFF'(cfg_off_w);
        wr_cfg.match  = CFG_W_DATA'(cfg_match_w);
        wr_cfg.buffer = CFG_W_BUF'(cfg_buffer_w);
`ifdef M_MATCH_MASK_EN
        wr_cfg.mask   = CFG_W_DATA'(cfg_mask_w);
`endif
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ch_wr[i] = cfg_vld_w && (cfg_ch_w == W_CH'(i));

        m_match_chan u_chan (
            .clk    (clk_net),
            .rst_n  (rst_net),
            .wr     (ch_wr[i]),
            .wr_cfg (wr_cfg),
            .load   (load),
            .beat   (acc),
            .sop    (in_sop_w),
            .idx    ((CFG_W_OFF + 1)'(idx)),
            .data   (CFG_W_DATA'(in_data_w)),
            .hit    (ch_hit[i]),
            .buffer (ch_buf[i])
        );
    end

    // Lowest-index hit wins; scanning downward lets the lowest assignment stick.
    always_comb begin
        sel_buf = DEFAULT_BUF;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_hit[i]) sel_buf = W_BUF'(ch_buf[i]);
        end
    end

    // FSM, word counter and registered egress.
    always_ff @(posedge clk_net) begin
        if (!rst_net) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            out_vld_r        <= 1'b0;
            out_sop_r        <= 1'b0;
            out_eop_r        <= 1'b0;
            out_length_r     <= '0;
            out_data_r       <= '0;
            out_buffer_vld_r <= 1'b0;
            out_buffer_r     <= '0;
            out_err_r        <= 1'b0;
        end else begin
            out_vld_r        <= acc;
            out_sop_r        <= acc && in_sop_w;
            out_eop_r        <= acc && in_eop_w;
            out_length_r     <= acc ? in_length_w : '0;
            out_data_r       <= acc ? in_data_w : '0;
            out_buffer_vld_r <= acc && in_eop_w;
            out_buffer_r     <= (acc && in_eop_w) ? sel_buf : '0;
            out_err_r        <= err;
            if (acc) begin
                cnt   <= cnt_nxt;
                state <= in_eop_w ? ST_IDLE : ST_PKT;
            end
        end
    end

endmodule
